// File: rtl/gdma_axi_pkg.sv
// -----------------------------------------------------------------------------
// gdma_axi_pkg
// Shared constants and FSM state types for the GDMA DDR-side AXI4 responder.
//   AXI_ADDR_W / AXI_DATA_W : bus widths (49-bit address, 32-bit data)
//   RESP_*                  : AXI response codes used by the responder
//   BURST_*                 : the two supported burst types
//   wr_state_e / rd_state_e : write and read FSM states
// -----------------------------------------------------------------------------
package gdma_axi_pkg;

  localparam int AXI_ADDR_W = 49;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP}  wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_e;

endpackage

// File: rtl/gdma_ddr_slave_if.sv
// -----------------------------------------------------------------------------
// gdma_ddr_slave_if
// AXI4 AW/W/B/AR/R signal bundle between the GDMA master and the DDR model.
//   modport slave  : responder view (addresses/data in, readies/responses out)
//   modport master : requester view (mirror of slave)
// cache/lock/prot/qos/region are intentionally not carried.
// -----------------------------------------------------------------------------
interface gdma_ddr_slave_if
  import gdma_axi_pkg::*;
();

  logic [AXI_ADDR_W-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;

  logic [AXI_DATA_W-1:0] wdata;
  logic [AXI_STRB_W-1:0] wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [AXI_ADDR_W-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;

  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/gdma_slv_ram.sv
// -----------------------------------------------------------------------------
// gdma_slv_ram
// Simple dual-port RAM, one byte-enabled write port and one registered read
// port. A read and write of the same word in one cycle returns the old data.
// Contents are not reset.
//   clk          : clock
//   we/waddr     : write enable / word index
//   wdata/wstrb  : write data / per-byte enables
//   re/raddr     : read enable / word index (rdata updates only when re=1)
//   rdata        : registered read data
// -----------------------------------------------------------------------------
module gdma_slv_ram #(
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic             re,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  // One byte-wide array per lane keeps the byte enables a plain write enable
  // on each bank.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_byte_q;

    always_ff @(posedge clk) begin
      if (we && wstrb[gi]) begin
        mem[waddr] <= wdata[gi*8 +: 8];
      end
      if (re) begin
        rd_byte_q <= mem[raddr];
      end
    end

    assign rdata[gi*8 +: 8] = rd_byte_q;
  end

endmodule

// File: rtl/gdma_ddr_slave.sv
// -----------------------------------------------------------------------------
// gdma_ddr_slave
// AXI4 responder standing in for the DDR end of the GDMA memory interface.
// Independent write (AW/W/B) and read (AR/R) FSMs, one outstanding burst each,
// served from an internal byte-writable RAM.
//   clk : clock
//   rst : asynchronous active-high reset
//   s   : gdma_ddr_slave_if.slave AXI bundle
// Optional build macro AXI_SLV_STALL_EN: an LFSR randomly withholds the
// readies and delays read data fetches to exercise master back-pressure.
// -----------------------------------------------------------------------------
module gdma_ddr_slave
  import gdma_axi_pkg::*;
#(
  parameter int                    MEM_DEPTH  = 4096,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR  = '0,
  parameter logic [15:0]           STALL_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  gdma_ddr_slave_if.slave  s
);

  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int TAG_LSB = 2 + IDX_W;

  typedef logic [IDX_W-1:0] idx_t;

  function automatic logic req_err(input logic [AXI_ADDR_W-1:0] addr,
                                   input logic [2:0] size,
                                   input logic [1:0] burst);
    return (addr[AXI_ADDR_W-1:TAG_LSB] != BASE_ADDR[AXI_ADDR_W-1:TAG_LSB]) ||
           (size != 3'd2) ||
           ((burst != BURST_FIXED) && (burst != BURST_INCR));
  endfunction

  function automatic idx_t idx_next(input idx_t idx, input logic [1:0] burst);
    return (burst == BURST_INCR) ? idx + 1'b1 : idx;
  endfunction

  // Byte offset bits are ignored by the decode.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s.awaddr[1:0], s.araddr[1:0]};

  // ---------------------------------------------------------------------------
  // Stall source
  // ---------------------------------------------------------------------------
  logic hs_ok;     // readies may be presented this cycle
  logic fetch_ok;  // read data may be (re)loaded this cycle

`ifdef AXI_SLV_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Galois form, taps 16,14,13,11.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= STALL_SEED;
    else     lfsr_q <= lfsr_d;
  end

  assign hs_ok    = lfsr_q[0];
  assign fetch_ok = lfsr_q[1];
`else
  assign hs_ok    = 1'b1;
  assign fetch_ok = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  logic        ram_we;
  logic        ram_re;
  idx_t        w_idx_q, w_idx_d;
  idx_t        r_idx_q, r_idx_d;
  logic [31:0] ram_rdata;

  gdma_slv_ram #(.DEPTH(MEM_DEPTH), .IDX_W(IDX_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (w_idx_q),
    .wdata (s.wdata),
    .wstrb (s.wstrb),
    .re    (ram_re),
    .raddr (r_idx_q),
    .rdata (ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  wr_state_e  w_state_q, w_state_d;
  logic [7:0] w_len_q, w_len_d;
  logic [7:0] w_beat_q, w_beat_d;
  logic [1:0] w_burst_q, w_burst_d;
  logic       w_err_q, w_err_d;
  logic       w_bad_q, w_bad_d;      // wlast seen in the wrong place
  logic [1:0] bresp_q, bresp_d;
  logic       aw_rdy_q, aw_rdy_d;
  logic       w_rdy_q, w_rdy_d;
  logic       bvalid_q, bvalid_d;

  logic aw_hs, w_hs, b_hs, w_final;

  assign s.awready = aw_rdy_q & hs_ok;
  assign s.wready  = w_rdy_q & hs_ok;
  assign s.bvalid  = bvalid_q;
  assign s.bresp   = bresp_q;

  assign aw_hs   = s.awvalid & s.awready;
  assign w_hs    = s.wvalid & s.wready;
  assign b_hs    = s.bvalid & s.bready;
  assign w_final = (w_beat_q == w_len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_burst_q <= BURST_FIXED;
      w_err_q   <= 1'b0;
      w_bad_q   <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_rdy_q  <= 1'b0;
      w_rdy_q   <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_burst_q <= w_burst_d;
      w_err_q   <= w_err_d;
      w_bad_q   <= w_bad_d;
      bresp_q   <= bresp_d;
      aw_rdy_q  <= aw_rdy_d;
      w_rdy_q   <= w_rdy_d;
      bvalid_q  <= bvalid_d;
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs)            w_state_d = W_DATA;
      W_DATA:  if (w_hs && w_final)  w_state_d = W_RESP;
      W_RESP:  if (b_hs)             w_state_d = W_IDLE;
      default:                       w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    w_idx_d   = w_idx_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_burst_d = w_burst_q;
    w_err_d   = w_err_q;
    w_bad_d   = w_bad_q;
    bresp_d   = bresp_q;
    ram_we    = 1'b0;

    if (aw_hs) begin
      w_idx_d   = s.awaddr[TAG_LSB-1:2];
      w_len_d   = s.awlen;
      w_burst_d = s.awburst;
      w_err_d   = req_err(s.awaddr, s.awsize, s.awburst);
      w_beat_d  = '0;
      w_bad_d   = 1'b0;
    end

    if (w_hs) begin
      // A misplaced wlast only poisons the response; the data still lands.
      ram_we   = !w_err_q;
      w_idx_d  = idx_next(w_idx_q, w_burst_q);
      w_beat_d = w_beat_q + 8'd1;
      w_bad_d  = w_bad_q | (s.wlast != w_final);
      if (w_final) begin
        bresp_d = (w_err_q || w_bad_d) ? RESP_SLVERR : RESP_OKAY;
      end
    end

    aw_rdy_d = (w_state_d == W_IDLE);
    w_rdy_d  = (w_state_d == W_DATA);
    bvalid_d = (w_state_d == W_RESP);
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  rd_state_e  r_state_q, r_state_d;
  logic [7:0] r_len_q, r_len_d;
  logic [7:0] r_beat_q, r_beat_d;
  logic [1:0] r_burst_q, r_burst_d;
  logic       r_err_q, r_err_d;
  logic [1:0] rresp_q, rresp_d;
  logic       ar_rdy_q, ar_rdy_d;
  logic       rvalid_q, rvalid_d;
  logic       rlast_q, rlast_d;

  logic ar_hs, r_hs;

  assign s.arready = ar_rdy_q & hs_ok;
  assign s.rvalid  = rvalid_q;
  assign s.rlast   = rlast_q;
  assign s.rresp   = rresp_q;
  // Error bursts return zero data; the RAM output only changes on a fetch, so
  // rdata holds while the master stalls.
  assign s.rdata   = (rvalid_q && !r_err_q) ? ram_rdata : '0;

  assign ar_hs = s.arvalid & s.arready;
  assign r_hs  = s.rvalid & s.rready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_burst_q <= BURST_FIXED;
      r_err_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      ar_rdy_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_burst_q <= r_burst_d;
      r_err_q   <= r_err_d;
      rresp_q   <= rresp_d;
      ar_rdy_q  <= ar_rdy_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs)    r_state_d = R_FETCH;
      R_FETCH: if (fetch_ok) r_state_d = R_DATA;
      R_DATA: begin
        if (r_hs) begin
          if (rlast_q)        r_state_d = R_IDLE;
          else if (!fetch_ok) r_state_d = R_FETCH;
        end
      end
      default:               r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    r_idx_d   = r_idx_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_burst_d = r_burst_q;
    r_err_d   = r_err_q;
    rresp_d   = rresp_q;

    // r_idx_q always points at the next word to fetch.
    ram_re = ((r_state_q == R_FETCH) && fetch_ok) ||
             ((r_state_q == R_DATA) && r_hs && !rlast_q && fetch_ok);

    if (ar_hs) begin
      r_idx_d   = s.araddr[TAG_LSB-1:2];
      r_len_d   = s.arlen;
      r_burst_d = s.arburst;
      r_err_d   = req_err(s.araddr, s.arsize, s.arburst);
      rresp_d   = r_err_d ? RESP_SLVERR : RESP_OKAY;
      r_beat_d  = '0;
    end

    if (ram_re) begin
      r_idx_d = idx_next(r_idx_q, r_burst_q);
    end

    if (r_hs && !rlast_q) begin
      r_beat_d = r_beat_q + 8'd1;
    end

    ar_rdy_d = (r_state_d == R_IDLE);
    rvalid_d = (r_state_d == R_DATA);
    rlast_d  = (r_state_d == R_DATA) && (r_beat_d == r_len_d);
  end

endmodule

// File: tb/tb_gdma_ddr_slave.sv
// -----------------------------------------------------------------------------
// tb_gdma_ddr_slave
// Scoreboarded bench for gdma_ddr_slave: expected R beats and B responses are
// queued when a burst is issued and compared as the DUT delivers them.
// -----------------------------------------------------------------------------
module tb_gdma_ddr_slave;
  import gdma_axi_pkg::*;

  localparam int DEPTH = 4096;
  localparam int IDX_W = 12;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gdma_ddr_slave_if bus();

  gdma_ddr_slave #(
    .MEM_DEPTH  (DEPTH),
    .BASE_ADDR  (49'h0),
    .STALL_SEED (16'hACE1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  int          tests = 0;
  int          fails = 0;
  rexp_t       rq[$];
  logic [1:0]  bq[$];
  logic [31:0] model [DEPTH];
  logic [31:0] wbuf [16];
  logic [3:0]  sbuf [16];
  int          rready_mode = 0;
  logic [31:0] prev_rdata;
  logic        prev_stall = 1'b0;
  rexp_t       mon_e;
  logic [1:0]  mon_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // R channel consumer: stability while stalled and per-beat scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (prev_stall) check("r_stable", bus.rdata, prev_rdata);
      if (bus.rvalid && bus.rready) begin
        if (rq.size() == 0) begin
          check("r_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = rq.pop_front();
          check("rdata", bus.rdata, mon_e.data);
          check("rresp", 32'(bus.rresp), 32'(mon_e.resp));
          check("rlast", 32'(bus.rlast), 32'(mon_e.last));
        end
      end
      prev_stall = bus.rvalid && !bus.rready;
      prev_rdata = bus.rdata;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // B channel consumer.
  always @(negedge clk) begin
    if (!rst && bus.bvalid && bus.bready) begin
      if (bq.size() == 0) begin
        check("b_unexpected", 32'd1, 32'd0);
      end else begin
        mon_b = bq.pop_front();
        check("bresp", 32'(bus.bresp), 32'(mon_b));
      end
    end
  end

  // rready: always high, or toggling every cycle.
  always @(posedge clk) begin
    #1;
    bus.rready = (rready_mode == 0) ? 1'b1 : ~bus.rready;
  end

  function automatic logic req_bad(input logic [48:0] addr, input logic [2:0] size,
                                   input logic [1:0] burst);
    return ((addr >> (2 + IDX_W)) != 49'd0) || (size != 3'd2) || (burst > 2'b01);
  endfunction

  task automatic merge(input int idx, input logic [31:0] d, input logic [3:0] st);
    for (int j = 0; j < 4; j++) begin
      if (st[j]) model[idx][j*8 +: 8] = d[j*8 +: 8];
    end
  endtask

  task automatic send_aw(input logic [48:0] addr, input int len, input logic [2:0] size,
                         input logic [1:0] burst);
    bit ok = 0;
    @(posedge clk); #1;
    bus.awaddr = addr; bus.awlen = 8'(len); bus.awsize = size; bus.awburst = burst;
    bus.awvalid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.awready) begin ok = 1; break; end
    end
    if (!ok) check("aw_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] st, input logic last);
    bit ok = 0;
    bus.wdata = d; bus.wstrb = st; bus.wlast = last; bus.wvalid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.wready) begin ok = 1; break; end
    end
    if (!ok) check("w_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic axi_write(input logic [48:0] addr, input int len, input logic [2:0] size,
                           input logic [1:0] burst, input int last_at);
    logic       err;
    logic [1:0] exp;
    int         idx;
    bit         ok = 0;
    err = req_bad(addr, size, burst);
    exp = (err || last_at != len) ? 2'b10 : 2'b00;
    bq.push_back(exp);
    send_aw(addr, len, size, burst);
    idx = int'(addr[2+IDX_W-1:2]);
    for (int b = 0; b <= len; b++) begin
      send_w(wbuf[b], sbuf[b], b == last_at);
      if (!err) merge(idx, wbuf[b], sbuf[b]);
      if (burst == BURST_INCR) idx = (idx + 1) % DEPTH;
    end
    for (int t = 0; t < 100; t++) begin
      if (bq.size() == 0) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("b_timeout", 32'd0, 32'd1);
    $display("[TB] WR addr=0x%0h len=%0d size=%0d burst=%0d wlast@%0d exp_bresp=%0d",
             addr, len, size, burst, last_at, exp);
  endtask

  task automatic axi_read(input logic [48:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input int check_lat);
    logic  err;
    int    idx;
    int    lat = 0;
    bit    ok = 0;
    rexp_t e;
    err = req_bad(addr, size, burst);
    idx = int'(addr[2+IDX_W-1:2]);
    for (int b = 0; b <= len; b++) begin
      e.data = err ? 32'h0 : model[idx];
      e.resp = err ? 2'b10 : 2'b00;
      e.last = (b == len);
      rq.push_back(e);
      if (burst == BURST_INCR) idx = (idx + 1) % DEPTH;
    end
    @(posedge clk); #1;
    bus.araddr = addr; bus.arlen = 8'(len); bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (bus.arready) begin ok = 1; break; end
    end
    if (!ok) check("ar_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      lat++;
      if (bus.rvalid) break;
    end
`ifndef AXI_SLV_STALL_EN
    if (check_lat != 0) check("r_latency", 32'(lat), 32'd2);
`endif
    ok = 0;
    for (int t = 0; t < 300; t++) begin
      if (rq.size() == 0) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) check("r_timeout", 32'd0, 32'd1);
    $display("[TB] RD addr=0x%0h len=%0d size=%0d burst=%0d rready_mode=%0d",
             addr, len, size, burst, rready_mode);
  endtask

  initial begin
    bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    for (int i = 0; i < 16; i++) begin wbuf[i] = '0; sbuf[i] = 4'hF; end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_wready",  32'(bus.wready),  32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("rst_rvalid",  32'(bus.rvalid),  32'd0);
    check("rst_rlast",   32'(bus.rlast),   32'd0);
    check("rst_bresp",   32'(bus.bresp),   32'd0);
    check("rst_rresp",   32'(bus.rresp),   32'd0);
    check("rst_rdata",   bus.rdata,        32'd0);
    rst = 1'b0;

    // 8-beat INCR write/read
    for (int i = 0; i < 8; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
    axi_write(49'h100, 7, 3'd2, BURST_INCR, 7);
    axi_read (49'h100, 7, 3'd2, BURST_INCR, 1);

    // Byte strobes
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    axi_write(49'h20, 0, 3'd2, BURST_INCR, 0);
    wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'b0101;
    axi_write(49'h20, 0, 3'd2, BURST_INCR, 0);
    axi_read (49'h20, 0, 3'd2, BURST_INCR, 1);

    // Errors: out of range read, bad size write, bad burst write
    axi_read (49'h4000, 3, 3'd2, BURST_INCR, 0);
    wbuf[0] = 32'h55555555; sbuf[0] = 4'hF;
    axi_write(49'h100, 0, 3'd1, BURST_INCR, 0);
    axi_write(49'h104, 0, 3'd2, 2'b10, 0);
    axi_read (49'h100, 1, 3'd2, BURST_INCR, 0);

    // Early wlast: all beats accepted and written, SLVERR
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hB0 + 32'(i); sbuf[i] = 4'hF; end
    axi_write(49'h500, 3, 3'd2, BURST_INCR, 1);
    axi_read (49'h500, 3, 3'd2, BURST_INCR, 0);

    // 16-beat read with toggling rready
    for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    axi_write(49'h300, 15, 3'd2, BURST_INCR, 15);
    rready_mode = 1;
    axi_read (49'h300, 15, 3'd2, BURST_INCR, 0);
    rready_mode = 0;

    // FIXED read returns the same word each beat
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    axi_write(49'h40, 0, 3'd2, BURST_INCR, 0);
    axi_read (49'h40, 3, 3'd2, BURST_FIXED, 0);

    // Reset after 2 of 8 write beats
    send_aw(49'h200, 7, 3'd2, BURST_INCR);
    for (int b = 0; b < 2; b++) begin
      send_w(32'hC0 + 32'(b), 4'hF, 1'b0);
      merge(128 + b, 32'hC0 + 32'(b), 4'hF);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_awready", 32'(bus.awready), 32'd0);
    check("mid_rst_wready",  32'(bus.wready),  32'd0);
    check("mid_rst_arready", 32'(bus.arready), 32'd0);
    check("mid_rst_bvalid",  32'(bus.bvalid),  32'd0);
    check("mid_rst_rvalid",  32'(bus.rvalid),  32'd0);
    $display("[TB] RST asserted mid-burst at beat 2 of 8");
    @(negedge clk);
    rst = 1'b0;
    wbuf[0] = 32'h0BADF00D; sbuf[0] = 4'hF;
    axi_write(49'h280, 0, 3'd2, BURST_INCR, 0);
    axi_read (49'h200, 1, 3'd2, BURST_INCR, 1);
    axi_read (49'h280, 0, 3'd2, BURST_INCR, 0);

    // Test 1 data still intact at the end
    axi_read (49'h100, 7, 3'd2, BURST_INCR, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
